// File: rtl/tlc_pkg.sv
// ============================================================================
// Module  : tlc_pkg
// Purpose : Shared phase encoding and default dwell times for traffic_light_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tlc_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WALK   = 2'd3
  } tlc_state_e;

  localparam int TLC_N_DIR_DEF    = 2;
  localparam int TLC_CNT_W_DEF    = 8;
  localparam int TLC_T_GREEN_DEF  = 20;
  localparam int TLC_T_YELLOW_DEF = 4;
  localparam int TLC_T_ALLRED_DEF = 2;
  localparam int TLC_T_WALK_DEF   = 10;

endpackage

`default_nettype wire

// File: rtl/tlc_dwell_timer.sv
// ============================================================================
// Module  : tlc_dwell_timer
// Purpose : Loadable down-counter; done flags the last cycle of a phase.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc_dwell_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturates at zero so a missed load can never wrap into a long dwell.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// Module  : traffic_light_ctrl
// Purpose : N-approach Moore traffic-light controller with latched pedestrian
//           service. Optional TLC_EMERGENCY_EN adds an emerg all-red override.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int  N_DIR    = TLC_N_DIR_DEF,
  parameter int  CNT_W    = TLC_CNT_W_DEF,
  parameter int  T_GREEN  = TLC_T_GREEN_DEF,
  parameter int  T_YELLOW = TLC_T_YELLOW_DEF,
  parameter int  T_ALLRED = TLC_T_ALLRED_DEF,
  parameter int  T_WALK   = TLC_T_WALK_DEF,
  localparam int DIR_W    = $clog2(N_DIR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
`ifdef TLC_EMERGENCY_EN
  input  logic             emerg,
`endif
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic             walk,
  output logic [1:0]       state_o,
  output logic [DIR_W-1:0] dir_o,
  output logic             ped_pending_o
);

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK - 1);
  localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(N_DIR - 1);

  tlc_state_e       state_q, state_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             ped_pending_q, ped_pending_d;
  logic             last_was_walk_q, last_was_walk_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_done;
  logic [N_DIR-1:0] dir_oh;

  tlc_dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALLRED)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d         = state_q;
    dir_d           = dir_q;
    ped_pending_d   = ped_pending_q | ped_req;
    last_was_walk_d = last_was_walk_q;
    tmr_load        = 1'b0;
    tmr_load_val    = LD_ALLRED;
    case (state_q)
      ST_ALLRED: if (tmr_done) begin
        tmr_load = 1'b1;
        if (ped_pending_q && !last_was_walk_q) begin
          state_d       = ST_WALK;
          tmr_load_val  = LD_WALK;
          ped_pending_d = ped_req;  // a request on the serving edge stays latched
        end else begin
          state_d         = ST_GREEN;
          tmr_load_val    = LD_GREEN;
          last_was_walk_d = 1'b0;
        end
      end
      ST_GREEN: if (tmr_done) begin
        state_d      = ST_YELLOW;
        tmr_load     = 1'b1;
        tmr_load_val = LD_YELLOW;
      end
      ST_YELLOW: if (tmr_done) begin
        state_d  = ST_ALLRED;
        tmr_load = 1'b1;
        dir_d    = (dir_q == DIR_LAST) ? '0 : dir_q + DIR_W'(1);
      end
      ST_WALK: if (tmr_done) begin
        state_d         = ST_ALLRED;
        tmr_load        = 1'b1;
        last_was_walk_d = 1'b1;
      end
      default: begin
        state_d  = ST_ALLRED;
        tmr_load = 1'b1;
      end
    endcase
`ifdef TLC_EMERGENCY_EN
    // Park in all-red with a fresh clearance dwell; dir and pending are kept.
    if (emerg) begin
      state_d         = ST_ALLRED;
      tmr_load        = 1'b1;
      tmr_load_val    = LD_ALLRED;
      dir_d           = dir_q;
      ped_pending_d   = ped_pending_q | ped_req;
      last_was_walk_d = last_was_walk_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_ALLRED;
      dir_q           <= '0;
      ped_pending_q   <= 1'b0;
      last_was_walk_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      ped_pending_q   <= ped_pending_d;
      last_was_walk_q <= last_was_walk_d;
    end
  end

  always_comb begin
    dir_oh = N_DIR'(1) << dir_q;
    red    = '1;
    yellow = '0;
    green  = '0;
    walk   = 1'b0;
    case (state_q)
      ST_GREEN: begin
        red   = ~dir_oh;
        green = dir_oh;
      end
      ST_YELLOW: begin
        red    = ~dir_oh;
        yellow = dir_oh;
      end
      ST_WALK: walk = 1'b1;
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign dir_o         = dir_q;
  assign ped_pending_o = ped_pending_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ============================================================================
// Module  : tb_traffic_light_ctrl
// Purpose : Directed self-checking bench for traffic_light_ctrl (2- and 3-approach).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl;
  import tlc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ped_req = 1'b0;
`ifdef TLC_EMERGENCY_EN
  logic emerg = 1'b0;
`endif

  logic [1:0] red, yellow, green, state_o;
  logic       walk, dir_o, ped_pending_o;
  logic [2:0] red3, yellow3, green3;
  logic [1:0] state3, dir3;
  logic       walk3, pend3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .N_DIR(2), .CNT_W(8), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(3)
  ) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req),
`ifdef TLC_EMERGENCY_EN
    .emerg(emerg),
`endif
    .red(red), .yellow(yellow), .green(green), .walk(walk),
    .state_o(state_o), .dir_o(dir_o), .ped_pending_o(ped_pending_o)
  );

  traffic_light_ctrl #(
    .N_DIR(3), .CNT_W(8), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(3)
  ) dut3 (
    .clk(clk), .rst(rst), .ped_req(1'b0),
`ifdef TLC_EMERGENCY_EN
    .emerg(1'b0),
`endif
    .red(red3), .yellow(yellow3), .green(green3), .walk(walk3),
    .state_o(state3), .dir_o(dir3), .ped_pending_o(pend3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pedestrian-free rotation with G=5, Y=2, AR=1: each approach owns an 8-cycle slot.
  function automatic logic [3:0] exp_rr(input int c, input int n);
    int m, blk, r;
    logic [1:0] st;
    m   = c % (8 * n);
    blk = m / 8;
    r   = m % 8;
    st  = (r == 0) ? ST_ALLRED : (r <= 5) ? ST_GREEN : ST_YELLOW;
    return {st, 2'(blk)};
  endfunction

  task automatic check_phase(input string tag, input logic [1:0] st, input logic d);
    logic [1:0] oh, er, ey, eg;
    oh = 2'b01 << d;
    er = (st == ST_GREEN || st == ST_YELLOW) ? ~oh : 2'b11;
    ey = (st == ST_YELLOW) ? oh : 2'b00;
    eg = (st == ST_GREEN) ? oh : 2'b00;
    check({tag, " state"}, 32'(state_o), 32'(st));
    check({tag, " dir"}, 32'(dir_o), 32'(d));
    check({tag, " red"}, 32'(red), 32'(er));
    check({tag, " yellow"}, 32'(yellow), 32'(ey));
    check({tag, " green"}, 32'(green), 32'(eg));
    check({tag, " walk"}, 32'(walk), 32'(st == ST_WALK));
    check({tag, " one_lamp"},
          32'(((red | yellow | green) == 2'b11) && ((red & yellow) == 2'b00) &&
              ((red & green) == 2'b00) && ((yellow & green) == 2'b00)), 32'd1);
  endtask

  initial begin
    logic [3:0] e;
    logic [1:0] st;
    logic       d;

    // Reset state and plain rotation (plus 3-approach wrap in parallel).
    do_reset();
    check("rst state", 32'(state_o), 32'd0);
    check("rst dir", 32'(dir_o), 32'd0);
    check("rst pend", 32'(ped_pending_o), 32'd0);
    check("rst red", 32'(red), 32'h3);
    check("rst yg", 32'({yellow, green, walk}), 32'd0);
    for (int c = 0; c < 32; c++) begin
      e = exp_rr(c, 2);
      check_phase($sformatf("rot c%0d", c), e[3:2], e[0]);
      e = exp_rr(c, 3);
      check($sformatf("rot3 c%0d state", c), 32'(state3), 32'(e[3:2]));
      check($sformatf("rot3 c%0d dir", c), 32'(dir3), 32'(e[1:0]));
      check($sformatf("rot3 c%0d green", c), 32'(green3),
            (e[3:2] == ST_GREEN) ? (32'd1 << e[1:0]) : 32'd0);
      step();
    end

    // Single-cycle pedestrian pulse during green[0].
    do_reset();
    step();
    step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    for (int c = 3; c <= 13; c++) begin
      if (c <= 7)       begin e = exp_rr(c, 2); st = e[3:2]; d = e[0]; end
      else if (c == 8)  begin st = ST_ALLRED; d = 1'b1; end
      else if (c <= 11) begin st = ST_WALK;   d = 1'b1; end
      else if (c == 12) begin st = ST_ALLRED; d = 1'b1; end
      else              begin st = ST_GREEN;  d = 1'b1; end
      check_phase($sformatf("ped c%0d", c), st, d);
      check($sformatf("ped c%0d pend", c), 32'(ped_pending_o), 32'(c <= 8));
      step();
    end

    // Held request: walks separated by a full green.
    do_reset();
    ped_req = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      if (c <= 8)       begin e = exp_rr(c, 2); st = e[3:2]; d = e[0]; end
      else if (c <= 11) begin st = ST_WALK;   d = 1'b1; end
      else if (c == 12) begin st = ST_ALLRED; d = 1'b1; end
      else if (c <= 17) begin st = ST_GREEN;  d = 1'b1; end
      else if (c <= 19) begin st = ST_YELLOW; d = 1'b1; end
      else if (c == 20) begin st = ST_ALLRED; d = 1'b0; end
      else if (c <= 23) begin st = ST_WALK;   d = 1'b0; end
      else if (c == 24) begin st = ST_ALLRED; d = 1'b0; end
      else              begin st = ST_GREEN;  d = 1'b0; end
      check_phase($sformatf("held c%0d", c), st, d);
      check($sformatf("held c%0d pend", c), 32'(ped_pending_o), 32'(c != 0));
      step();
    end
    ped_req = 1'b0;

    // Reset asserted in the second yellow[1] cycle with a request pending.
    do_reset();
    for (int i = 0; i < 10; i++) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("mrst pend_before", 32'(ped_pending_o), 32'd1);
    for (int i = 0; i < 4; i++) step();
    check_phase("mrst c15", ST_YELLOW, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_phase("mrst after", ST_ALLRED, 1'b0);
    check("mrst pend", 32'(ped_pending_o), 32'd0);
    step();
    check_phase("mrst green", ST_GREEN, 1'b0);

`ifdef TLC_EMERGENCY_EN
    // Emergency hold interrupting green[1]; resumes with a full green[1].
    do_reset();
    for (int i = 0; i < 11; i++) step();
    check_phase("emg c11", ST_GREEN, 1'b1);
    emerg = 1'b1;
    for (int c = 12; c <= 15; c++) begin
      step();
      if (c == 15) emerg = 1'b0;
      check_phase($sformatf("emg c%0d", c), ST_ALLRED, 1'b1);
    end
    for (int c = 16; c <= 21; c++) begin
      step();
      check_phase($sformatf("emg c%0d", c), (c <= 20) ? ST_GREEN : ST_YELLOW, 1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised Moore traffic-light controller for an N-approach intersection with pedestrian service. Each phase has its own programmable dwell time, enforced by a down-counter. Pedestrian requests are latched until served. The block sits between the push-button synchroniser and the lamp drivers, and supersedes the fixed 5-state single-approach controller.

## Interface
Parameters:
- N_DIR, 2: number of vehicle approaches served in round-robin; ≥2.
- CNT_W, 8: dwell-timer width.
- T_GREEN, 20: green dwell in cycles; 1..2^CNT_W.
- T_YELLOW, 4: yellow dwell in cycles; 1..2^CNT_W.
- T_ALLRED, 2: all-red clearance dwell in cycles; 1..2^CNT_W.
- T_WALK, 10: pedestrian walk dwell in cycles; 1..2^CNT_W.
- DIR_W, $clog2(N_DIR): derived; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ped_req  in  1  pedestrian request; already synchronised; level or pulse.
- red  out  N_DIR  red lamp per approach.
- yellow  out  N_DIR  yellow lamp per approach.
- green  out  N_DIR  green lamp per approach.
- walk  out  1  pedestrian walk lamp.
- state_o  out  2  current phase (tlc_state_e encoding).
- dir_o  out  DIR_W  approach currently owning or next owning green.
- ped_pending_o  out  1  latched, unserved pedestrian request.

## Operation
- States: ST_ALLRED, ST_GREEN, ST_YELLOW, ST_WALK.
- Registered state: state, dir, timer, ped_pending, last_was_walk.
- Outputs are a combinational decode of registered state only. There is no input-to-output path.
- ST_ALLRED: red all 1; yellow, green and walk 0.
  - On timer==0: go to ST_WALK if ped_pending and !last_was_walk; otherwise go to ST_GREEN.
- ST_GREEN: green[dir]=1 and red[dir]=0; all other approaches red.
  - On timer==0: go to ST_YELLOW.
- ST_YELLOW: yellow[dir]=1 and red[dir]=0; all other approaches red.
  - On timer==0: go to ST_ALLRED and advance dir. N_DIR−1 wraps to 0.
- ST_WALK: red all 1, walk=1.
  - On timer==0: go to ST_ALLRED; dir is unchanged.
- last_was_walk is set on the WALK→ALLRED transition and cleared on the ALLRED→GREEN transition. This guarantees at least one green between consecutive walks.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the ALLRED→WALK edge.
  - Set wins when both happen on the same edge.
- Exactly one lamp per approach is lit in every state. Any illegal state decodes as ST_ALLRED lamps and returns to ST_ALLRED on the next edge.

## Timing
- Reset (rst=1 on an edge):
  - state=ST_ALLRED, dir=0, timer=T_ALLRED−1, ped_pending=0, last_was_walk=0.
  - Outputs: red all 1; yellow, green and walk 0; state_o=0; dir_o=0; ped_pending_o=0.
- Reset mid-phase takes effect on the next edge and overrides every other update.
- Timer is loaded with T_x−1 on entry to phase x and decrements each cycle. The exit transition occurs on the edge where timer==0, so each phase lasts exactly T_x cycles.
- ped_req to ped_pending_o latency: 1 cycle.
- Worst-case walk latency is bounded by the remaining current phase plus T_YELLOW + T_ALLRED, plus T_GREEN + T_YELLOW + T_ALLRED when last_was_walk is set.
- Rotation period with no pedestrians: N_DIR·(T_GREEN+T_YELLOW+T_ALLRED).

## Configuration
- TLC_EMERGENCY_EN defined:
  - Adds input emerg (1 bit).
  - Any cycle with emerg=1 forces state=ST_ALLRED and timer=T_ALLRED−1 on the next edge, holding there while emerg stays high.
  - dir and ped_pending are preserved.
  - After deassertion: full T_ALLRED, then normal ALLRED exit rules. An interrupted green or yellow restarts as a full green on the same dir.
  - rst has priority over emerg.
- TLC_EMERGENCY_EN undefined: no emerg port; behaviour exactly as above.

## Structure
- tlc_pkg:
  - typedef enum logic [1:0] tlc_state_e: ST_ALLRED=0, ST_GREEN=1, ST_YELLOW=2, ST_WALK=3.
  - Shared default-dwell localparams.
- Sub-module tlc_dwell_timer: CNT_W loadable down-counter with load, load_val and done (timer==0) outputs. Instantiated once.

## Test plan
Parameters for all cases unless noted: N_DIR=2, T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_WALK=3.
- Release rst, no ped_req → ALLRED 1 cycle, green[0] 5, yellow[0] 2, ALLRED 1, green[1] 5, yellow[1] 2; period 16 cycles; exactly one lamp per approach every cycle.
- 1-cycle ped_req during green[0] → ped_pending_o=1 next cycle; after yellow[0] and 1 ALLRED cycle, walk=1 with red=2'b11 for 3 cycles; then 1 ALLRED cycle and green[1].
- ped_req held at 1 → walks never back-to-back: WALK, ALLRED, green[1], yellow[1], ALLRED, WALK, …; ped_pending_o stays 1.
- rst asserted in the 2nd yellow[1] cycle → next cycle: red=2'b11, dir_o=0, ped_pending_o=0; then 1 ALLRED cycle and green[0].
- N_DIR=3 → green order 0,1,2,0; dir_o wraps 2→0 on the YELLOW→ALLRED edge.
- TLC_EMERGENCY_EN, emerg high for 4 cycles starting in the 3rd green[1] cycle → all red from the next cycle through deassertion + 1 cycle; then green[1] for a full 5 cycles.
